wgt_bram_loader: RTL and testbench
==================================

# wgt_bram_loader

Writer side of the weight BRAM. It accepts a word stream from the host DMA and unpacks each word into `DATA_WIDTH`-bit bytes. The bytes are written sequentially into port A of the weight BRAM in conv1 W, conv1 a, conv2 W, conv2 a order. When the image is complete it asserts `wgt_bram_load_done`, which the conv schedulers use before reading port B.

## Interface
- `DATA_WIDTH`, 8: BRAM word width.
- `IN_WIDTH`, 32: stream word width; must be a multiple of `DATA_WIDTH`. BPB = `IN_WIDTH/DATA_WIDTH` (4).
- `NUM_FEATURE_IN`, 1433; `NUM_FEATURE_OUT`, 16; `NUM_FEATURE_FINAL`, 7.
- Derived:
  - CONV1_DEPTH = `NUM_FEATURE_OUT*(NUM_FEATURE_IN+2)` = 22960.
  - WEIGHT_DEPTH = CONV1_DEPTH + `NUM_FEATURE_FINAL*(NUM_FEATURE_OUT+2)` = 23086.
  - WEIGHT_ADDR_W = clog2(WEIGHT_DEPTH) = 15.
  - NUM_BEATS = ceil(WEIGHT_DEPTH/BPB) = 5772.
- Reset convention (already decided): one clock; reset is asynchronous and active-high.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear_i` in 1: synchronous restart of the load; single-cycle pulse.
- `s_data_i` in IN_WIDTH: stream word; lane 0 is `[DATA_WIDTH-1:0]` and is written first.
- `s_vld_i` in 1: stream valid.
- `s_last_i` in 1: marks the final beat.
- `s_rdy_o` out 1: stream ready.
- `wgt_bram_ena` out 1: port-A enable.
- `wgt_bram_wea` out 1: port-A write enable.
- `wgt_bram_addra` out WEIGHT_ADDR_W: port-A address.
- `wgt_bram_dina` out DATA_WIDTH: port-A write data.
- `conv1_done_o` out 1: sticky; conv1 region is written.
- `wgt_bram_load_done` out 1: sticky; whole image is written.
- `err_o` out 1: sticky; framing error.

## Operation
- States:
  - LOAD is entered on reset or `clear_i`.
  - DONE is entered when the byte at address WEIGHT_DEPTH-1 is written.
  - ERR is entered when `s_last_i` arrives on an accepted beat other than beat NUM_BEATS-1.
- Beat counter (clog2(NUM_BEATS)+1 bits) counts accepted beats. Byte address counter (WEIGHT_ADDR_W bits) counts written bytes.
- A one-beat holding register with a lane index (0..BPB-1) serialises the beat, one byte per cycle.
- `s_rdy_o` = state==LOAD && (holding register empty || lane index==BPB-1 with a write this cycle). A handshake is `s_vld_i && s_rdy_o`.
- Each cycle the holding register is occupied in LOAD:
  - Write lane `lane` to address `addr`.
  - Increment `addr`.
  - Advance `lane`; free the register after lane BPB-1.
- Final beat: only lanes 0..(WEIGHT_DEPTH-1 mod BPB) are written; lanes above that are discarded without a write. With the defaults, lanes 0-1 are written and lanes 2-3 dropped.
- Final beat accepted with `s_last_i`=0: set `err_o`, but still finish the load and reach DONE.
- ERR: stop writing and drop the remainder of the held beat. `s_rdy_o`=0; `wgt_bram_load_done` stays 0; `conv1_done_o` keeps its value.
- DONE: `s_rdy_o`=0, no writes, `wgt_bram_load_done`=1.
- `clear_i`, from any state:
  - Next cycle: state LOAD, counters 0, holding register empty, all three status flags 0.
  - A beat presented in the `clear_i` cycle is not accepted.
- `clear_i` overrides a same-cycle handshake and a same-cycle write: the write in that cycle does not occur.
- Reset mid-load has the same effect as `clear_i`, asynchronously. The BRAM contents are not touched.

## Timing
- Reset values: `s_rdy_o`=0, `wgt_bram_ena`=0, `wgt_bram_wea`=0, `wgt_bram_addra`=0, `wgt_bram_dina`=0, `conv1_done_o`=0, `wgt_bram_load_done`=0, `err_o`=0.
- `s_rdy_o` is 1 from the first cycle after `rst` deasserts.
- All BRAM port-A outputs are registered. A beat accepted at edge t writes lane k during cycle t+1+k (`ena`=`wea`=1, address and data valid in that cycle).
- Back-to-back valid beats sustain 1 byte per cycle with no bubbles. A full default load takes 23086 write cycles.
- Gaps in `s_vld_i` produce cycles with `ena`=`wea`=0; the address holds.
- `conv1_done_o` rises the cycle after the write to address CONV1_DEPTH-1.
- `wgt_bram_load_done` rises the cycle after the write to WEIGHT_DEPTH-1.
- `err_o` rises the cycle after the offending handshake.

## Test plan
Small config: `NUM_FEATURE_IN`=3, `NUM_FEATURE_OUT`=2, `NUM_FEATURE_FINAL`=1 gives WEIGHT_DEPTH=14, CONV1_DEPTH=10, NUM_BEATS=4.
- Reset check: hold `rst` -> all outputs 0. Release `rst` -> `s_rdy_o`=1.
- Continuous load, small config: 4 beats with bytes 0x00..0x0F, `s_last_i` on beat 3.
  - Writes: addresses 0..13 with data 0x00..0x0D on consecutive cycles; bytes 0x0E and 0x0F are never written.
  - `conv1_done_o` rises 1 cycle after the addr-9 write; `wgt_bram_load_done` rises 1 cycle after the addr-13 write.
  - `err_o` stays 0; `s_rdy_o` stays 0 afterwards.
- Bubbles/backpressure: random `s_vld_i` gaps -> identical address/data sequence, `wea`=0 during gaps. `s_rdy_o` is low for exactly 3 cycles per accepted beat when the next beat is already waiting.
- Early last: `s_last_i` on beat 1 -> `err_o`=1, no further writes, `wgt_bram_load_done` stays 0. A `clear_i` pulse then gives a clean reload to done.
- Missing last: beat 3 without `s_last_i` -> `err_o`=1 and `wgt_bram_load_done`=1.
- Clear/reset mid-load:
  - `clear_i` during beat 2 -> the next load restarts at addr 0 and completes correctly.
  - Async `rst` mid-write -> `wea` drops immediately.
- Default config full load: 5772 beats -> exactly 23086 writes, `conv1_done_o` after addr 22959, done after addr 23085.

Source files
------------

// File: rtl/wgt_bram_loader_if.sv
// wgt_bram_loader_if: host DMA word stream feeding the weight BRAM loader
`timescale 1ns/1ps
interface wgt_bram_loader_if #(
  parameter int IN_WIDTH = 32
) ();
  logic [IN_WIDTH-1:0] s_data_i;
  logic                s_vld_i;
  logic                s_last_i;
  logic                s_rdy_o;
  modport master (output s_data_i, s_vld_i, s_last_i, input s_rdy_o);
  modport slave (input s_data_i, s_vld_i, s_last_i, output s_rdy_o);
endinterface

// File: rtl/wgt_bram_loader.sv
// wgt_bram_loader: unpacks stream words into bytes and writes them sequentially into weight BRAM port A
`timescale 1ns/1ps
module wgt_bram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_WIDTH = 32,
  parameter int NUM_FEATURE_IN = 1433,
  parameter int NUM_FEATURE_OUT = 16,
  parameter int NUM_FEATURE_FINAL = 7,
  localparam int BPB = IN_WIDTH / DATA_WIDTH,
  localparam int CONV1_DEPTH = NUM_FEATURE_OUT * (NUM_FEATURE_IN + 2),
  localparam int WEIGHT_DEPTH = CONV1_DEPTH + NUM_FEATURE_FINAL * (NUM_FEATURE_OUT + 2),
  localparam int WEIGHT_ADDR_W = $clog2(WEIGHT_DEPTH),
  localparam int NUM_BEATS = (WEIGHT_DEPTH + BPB - 1) / BPB
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  wgt_bram_loader_if.slave         s,
  output logic                     wgt_bram_ena,
  output logic                     wgt_bram_wea,
  output logic [WEIGHT_ADDR_W-1:0] wgt_bram_addra,
  output logic [DATA_WIDTH-1:0]    wgt_bram_dina,
  output logic                     conv1_done_o,
  output logic                     wgt_bram_load_done,
  output logic                     err_o
);
  localparam int BEAT_W = $clog2(NUM_BEATS) + 1;
  localparam int LANE_W = BPB > 1 ? $clog2(BPB) : 1;
  localparam logic [WEIGHT_ADDR_W-1:0] LAST_ADDR = WEIGHT_ADDR_W'(WEIGHT_DEPTH - 1);
  localparam logic [WEIGHT_ADDR_W-1:0] C1_ADDR = WEIGHT_ADDR_W'(CONV1_DEPTH - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPB - 1);

  typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;

  state_t                   state_q, state_d;
  logic [BEAT_W-1:0]        beat_q, beat_d;
  logic [WEIGHT_ADDR_W-1:0] addr_q, addr_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [IN_WIDTH-1:0]      hold_q, hold_d;
  logic                     ena_q, ena_d;
  logic [WEIGHT_ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0]    dina_q, dina_d;
  logic                     c1_q, c1_d, done_q, done_d, err_q, err_d;
  logic                     last_byte, rdy, hs, final_beat, early, ld, cont;

  // ena_q doubles as "holding register occupied": the port shows lane_q of the held beat while it is set;
  // hold_d keeps the not-yet-written lanes shifted down so the next lane is always in the low byte
  always_comb begin
    last_byte = ena_q && addra_q == LAST_ADDR;
    rdy = !rst && !clear_i && state_q == LOAD && (!ena_q || (lane_q == LAST_LANE && !last_byte));
    hs = s.s_vld_i && rdy;
    final_beat = beat_q == LAST_BEAT;
    early = hs && s.s_last_i && !final_beat;
    ld = hs && !early;
    cont = ena_q && lane_q != LAST_LANE && !last_byte;
    state_d = early ? ERR : last_byte ? DONE : state_q;
    beat_d = hs ? beat_q + BEAT_W'(1) : beat_q;
    addr_d = addr_q + WEIGHT_ADDR_W'(ena_q);
    ena_d = ld || cont;
    lane_d = ld ? '0 : cont ? lane_q + LANE_W'(1) : lane_q;
    hold_d = ld ? s.s_data_i >> DATA_WIDTH : cont ? hold_q >> DATA_WIDTH : hold_q;
    dina_d = ld ? s.s_data_i[DATA_WIDTH-1:0] : cont ? hold_q[DATA_WIDTH-1:0] : dina_q;
    addra_d = ena_d ? addr_d : addra_q;
    c1_d = c1_q || (ena_q && addra_q == C1_ADDR);
    done_d = done_q || last_byte;
    err_d = err_q || (hs && s.s_last_i != final_beat);
    if (clear_i) begin
      state_d = LOAD;
      beat_d = '0;
      addr_d = '0;
      ena_d = 1'b0;
      lane_d = '0;
      hold_d = '0;
      dina_d = '0;
      addra_d = '0;
      c1_d = 1'b0;
      done_d = 1'b0;
      err_d = 1'b0;
    end
  end

  // state, counters, holding register and registered port-A outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      beat_q <= '0;
      addr_q <= '0;
      lane_q <= '0;
      hold_q <= '0;
      ena_q <= 1'b0;
      addra_q <= '0;
      dina_q <= '0;
      c1_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      addr_q <= addr_d;
      lane_q <= lane_d;
      hold_q <= hold_d;
      ena_q <= ena_d;
      addra_q <= addra_d;
      dina_q <= dina_d;
      c1_q <= c1_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign s.s_rdy_o = rdy;
  assign wgt_bram_ena = ena_q && !clear_i;
  assign wgt_bram_wea = ena_q && !clear_i;
  assign wgt_bram_addra = addra_q;
  assign wgt_bram_dina = dina_q;
  assign conv1_done_o = c1_q;
  assign wgt_bram_load_done = done_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_wgt_bram_loader.sv
// tb_wgt_bram_loader: directed checks of the weight BRAM loader in a small and the default configuration
`timescale 1ns/1ps
module tb_wgt_bram_loader;
  logic clk = 0, rst = 1, clear_a = 0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  wgt_bram_loader_if ia ();
  wgt_bram_loader_if ib ();
  logic a_ena, a_wea, a_c1, a_dn, a_err;
  logic [3:0] a_addr;
  logic [7:0] a_din;
  logic b_ena, b_wea, b_c1, b_dn, b_err;
  logic [14:0] b_addr;
  logic [7:0] b_din;
  logic [3:0] wa[$];
  logic [7:0] wd[$];
  int wc[$];
  int c1_cyc = -1, dn_cyc = -1;
  int bcnt = 0, bbad = 0, bc1w = -1, bdnw = -1, bc1c = -1, bdnc = -1;

  wgt_bram_loader #(.NUM_FEATURE_IN(3), .NUM_FEATURE_OUT(2), .NUM_FEATURE_FINAL(1)) dut_a (
    .clk(clk), .rst(rst), .clear_i(clear_a), .s(ia),
    .wgt_bram_ena(a_ena), .wgt_bram_wea(a_wea), .wgt_bram_addra(a_addr), .wgt_bram_dina(a_din),
    .conv1_done_o(a_c1), .wgt_bram_load_done(a_dn), .err_o(a_err));

  wgt_bram_loader dut_b (
    .clk(clk), .rst(rst), .clear_i(1'b0), .s(ib),
    .wgt_bram_ena(b_ena), .wgt_bram_wea(b_wea), .wgt_bram_addra(b_addr), .wgt_bram_dina(b_din),
    .conv1_done_o(b_c1), .wgt_bram_load_done(b_dn), .err_o(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    #2;
    if (a_wea) begin
      wa.push_back(a_addr);
      wd.push_back(a_din);
      wc.push_back(cyc);
    end
    if (a_c1 && c1_cyc < 0) c1_cyc = cyc;
    if (a_dn && dn_cyc < 0) dn_cyc = cyc;
  end

  always @(negedge clk) begin
    #2;
    if (b_wea) begin
      if (b_addr !== 15'(bcnt) || b_din !== 8'(bcnt)) bbad++;
      if (bcnt == 22959) bc1w = cyc;
      if (bcnt == 23085) bdnw = cyc;
      bcnt++;
    end
    if (b_c1 && bc1c < 0) bc1c = cyc;
    if (b_dn && bdnc < 0) bdnc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] beat(input int i);
    return {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_log();
    wa.delete();
    wd.delete();
    wc.delete();
    c1_cyc = -1;
    dn_cyc = -1;
  endtask

  task automatic send_a(input logic [31:0] d, input logic l, output int w);
    bit ok;
    ia.s_data_i = d;
    ia.s_vld_i = 1;
    ia.s_last_i = l;
    ok = 0;
    w = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      ok = ia.s_rdy_o;
      if (!ok) w++;
      @(negedge clk);
    end
    ia.s_vld_i = 0;
    ia.s_last_i = 0;
    chk("a_accept", 32'(ok), 1);
  endtask

  task automatic send_b(input logic [31:0] d, input logic l);
    bit ok;
    ib.s_data_i = d;
    ib.s_vld_i = 1;
    ib.s_last_i = l;
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      #1;
      ok = ib.s_rdy_o;
      @(negedge clk);
    end
    ib.s_vld_i = 0;
    ib.s_last_i = 0;
    chk("b_accept", 32'(ok), 1);
  endtask

  task automatic load4(input logic lst, input bit gaps);
    int w;
    for (int i = 0; i < 4; i++) begin
      send_a(beat(i), lst && i == 3, w);
      if (!gaps && i > 0) chk($sformatf("rdy_low_beat%0d", i), 32'(w), 3);
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic chk_seq(input string tag, input int n);
    chk({tag, "_count"}, 32'(wa.size()), 32'(n));
    for (int i = 0; i < wa.size() && i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(i));
    end
  endtask

  task automatic pulse_clear();
    clear_a = 1;
    @(negedge clk);
    clear_a = 0;
  endtask

  initial begin
    int w;
    ia.s_data_i = 0; ia.s_vld_i = 0; ia.s_last_i = 0;
    ib.s_data_i = 0; ib.s_vld_i = 0; ib.s_last_i = 0;
    idle(2);
    #1;
    chk("rst_rdy", 32'(ia.s_rdy_o), 0);
    chk("rst_ena", 32'(a_ena), 0);
    chk("rst_wea", 32'(a_wea), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_din", 32'(a_din), 0);
    chk("rst_flags", {29'd0, a_c1, a_dn, a_err}, 0);
    rst = 0;
    @(negedge clk);
    #1;
    chk("rel_rdy", 32'(ia.s_rdy_o), 1);
    @(negedge clk);

    reset_log();
    load4(1, 0);
    idle(6);
    chk_seq("cont", 14);
    for (int i = 1; i < wc.size(); i++) chk($sformatf("cont_cyc%0d", i), 32'(wc[i]), 32'(wc[0] + i));
    chk("cont_c1_timing", 32'(c1_cyc), 32'(wc[9] + 1));
    chk("cont_done_timing", 32'(dn_cyc), 32'(wc[13] + 1));
    chk("cont_err", 32'(a_err), 0);
    chk("cont_done", 32'(a_dn), 1);
    chk("cont_rdy_after", 32'(ia.s_rdy_o), 0);

    pulse_clear();
    #1;
    chk("clr_flags", {29'd0, a_c1, a_dn, a_err}, 0);
    chk("clr_rdy", 32'(ia.s_rdy_o), 1);
    @(negedge clk);

    reset_log();
    load4(1, 1);
    idle(6);
    chk_seq("gaps", 14);
    chk("gaps_done", 32'(a_dn), 1);
    chk("gaps_err", 32'(a_err), 0);

    pulse_clear();
    reset_log();
    send_a(beat(0), 0, w);
    send_a(beat(1), 1, w);
    idle(8);
    chk_seq("early", 4);
    chk("early_err", 32'(a_err), 1);
    chk("early_done", 32'(a_dn), 0);
    chk("early_rdy", 32'(ia.s_rdy_o), 0);
    pulse_clear();
    reset_log();
    load4(1, 0);
    idle(6);
    chk_seq("reload", 14);
    chk("reload_done", 32'(a_dn), 1);
    chk("reload_err", 32'(a_err), 0);

    pulse_clear();
    reset_log();
    load4(0, 0);
    idle(6);
    chk_seq("nolast", 14);
    chk("nolast_err", 32'(a_err), 1);
    chk("nolast_done", 32'(a_dn), 1);

    pulse_clear();
    reset_log();
    send_a(beat(0), 0, w);
    send_a(beat(1), 0, w);
    send_a(beat(2), 0, w);
    @(negedge clk);
    clear_a = 1;
    #1;
    chk("midclr_wea", 32'(a_wea), 0);
    @(negedge clk);
    clear_a = 0;
    idle(2);
    chk_seq("midclr", 9);
    chk("midclr_c1", 32'(a_c1), 0);
    reset_log();
    load4(1, 0);
    idle(6);
    chk_seq("after_clr", 14);
    chk("after_clr_done", 32'(a_dn), 1);

    pulse_clear();
    send_a(beat(0), 0, w);
    #3;
    rst = 1;
    #1;
    chk("arst_wea", 32'(a_wea), 0);
    chk("arst_ena", 32'(a_ena), 0);
    @(negedge clk);
    rst = 0;
    reset_log();
    #1;
    chk("arst_rdy", 32'(ia.s_rdy_o), 1);
    @(negedge clk);
    load4(1, 0);
    idle(6);
    chk_seq("after_rst", 14);

    for (int i = 0; i < 5772; i++) send_b(beat(i), i == 5771);
    idle(10);
    chk("big_writes", 32'(bcnt), 23086);
    chk("big_seq_bad", 32'(bbad), 0);
    chk("big_done", 32'(b_dn), 1);
    chk("big_err", 32'(b_err), 0);
    chk("big_c1_timing", 32'(bc1c), 32'(bc1w + 1));
    chk("big_done_timing", 32'(bdnc), 32'(bdnw + 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
